// File: rtl/clk_en_gen.sv
// Lock-qualified reset sequencer with NUM_CH run-time divisible clock-enable strobes.
// Optional square-wave outputs are built when CLKEN_SQUARE_EN is defined.
module clk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                    clkin,
  input  logic                    reset,
  input  logic                    lock_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic                    sync_i,
  output logic                    rst_o,
  output logic [NUM_CH-1:0]       ce_o,
  output logic [NUM_CH-1:0]       sq_o,
  output logic                    run_o
);

  localparam int LCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STABLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic                           lock_meta_q, lock_meta_d;
  logic                           lock_s_q, lock_s_d;
  logic [LCNT_W-1:0]              lcnt_q, lcnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0]   div_act_q, div_act_d;
  logic [NUM_CH-1:0]              ce_q, ce_d;
  logic                           rst_q, rst_d;
  logic                           run_q, run_d;
  logic                           run_entry_s;

  // Lock synchroniser and qualification state machine.
  always_comb begin
    lock_meta_d = lock_i;
    lock_s_d    = lock_meta_q;
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    case (state_q)
      ST_RST: begin
        state_d = ST_WAIT;
        lcnt_d  = {LCNT_W{1'b0}};
      end
      ST_WAIT: begin
        lcnt_d = {LCNT_W{1'b0}};
        if (lock_s_q) begin
          state_d = ST_STABLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STABLE: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT;
          lcnt_d  = {LCNT_W{1'b0}};
        end else if (lcnt_q == LCNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          lcnt_d = lcnt_q + LCNT_W'(1'b1);
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RST;
        lcnt_d  = {LCNT_W{1'b0}};
      end
    endcase
  end

  // Outputs are computed from the next state so they change together with it.
  always_comb begin
    run_d       = (state_d == ST_RUN);
    rst_d       = ~run_d;
    run_entry_s = run_d && (state_q != ST_RUN);
    cnt_d       = cnt_q;
    div_act_d   = div_act_q;
    ce_d        = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (!run_d) begin
        cnt_d[i] = {DIV_W{1'b0}};
      end else if (run_entry_s || sync_i || (cnt_q[i] == div_act_q[i])) begin
        cnt_d[i]     = {DIV_W{1'b0}};
        div_act_d[i] = div_i[i*DIV_W +: DIV_W];
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1'b1);
      end
      ce_d[i] = run_d && (cnt_d[i] == div_act_d[i]);
    end
  end

  // Sequencer, divider and output registers.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= ST_RST;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      lcnt_q      <= {LCNT_W{1'b0}};
      cnt_q       <= {(NUM_CH*DIV_W){1'b0}};
      div_act_q   <= {(NUM_CH*DIV_W){1'b0}};
      ce_q        <= {NUM_CH{1'b0}};
      rst_q       <= 1'b1;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      lcnt_q      <= lcnt_d;
      cnt_q       <= cnt_d;
      div_act_q   <= div_act_d;
      ce_q        <= ce_d;
      rst_q       <= rst_d;
      run_q       <= run_d;
    end
  end

`ifdef CLKEN_SQUARE_EN
  logic [NUM_CH-1:0] sq_q, sq_d;

  // A restart (entry or sync) clears the square before the first toggle.
  always_comb begin
    sq_d = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (!run_d) begin
        sq_d[i] = 1'b0;
      end else if (run_entry_s || sync_i) begin
        sq_d[i] = ce_d[i];
      end else begin
        sq_d[i] = sq_q[i] ^ ce_d[i];
      end
    end
  end

  // Square-wave toggle registers.
  always_ff @(posedge clkin) begin
    if (reset) begin
      sq_q <= {NUM_CH{1'b0}};
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq_o = sq_q;
`else
  assign sq_o = {NUM_CH{1'b0}};
`endif

  assign rst_o = rst_q;
  assign run_o = run_q;
  assign ce_o  = ce_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Randomised scoreboard bench for clk_en_gen; the reference tracks lock streaks and
// absolute strobe cycle numbers. CLKEN_SQUARE_EN selects the square-wave expectation.
module tb_clk_en_gen;

  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int LOCK = 16;

  logic                clkin;
  logic                reset;
  logic                lock_i;
  logic [NCH*DW-1:0]   div_i;
  logic                sync_i;
  logic                rst_o;
  logic [NCH-1:0]      ce_o;
  logic [NCH-1:0]      sq_o;
  logic                run_o;

  clk_en_gen #(.NUM_CH(NCH), .DIV_W(DW), .LOCK_CYCLES(LOCK)) dut (
    .clkin (clkin),
    .reset (reset),
    .lock_i(lock_i),
    .div_i (div_i),
    .sync_i(sync_i),
    .rst_o (rst_o),
    .ce_o  (ce_o),
    .sq_o  (sq_o),
    .run_o (run_o)
  );

  typedef struct packed {
    logic           rst;
    logic           run;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] sq;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  bit             m_s1 = 1'b0, m_s2 = 1'b0, m_in_rst = 1'b0, m_run = 1'b0;
  int             m_streak = 0;
  int             m_cyc = 0;
  int             m_next[NCH];
  bit [NCH-1:0]   m_sq = '0;

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Predict the outputs of the cycle after the one whose inputs are now applied.
  task automatic model_push();
    exp_t e;
    int   dv;
    e = '0;
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_streak = 0; m_run = 1'b0; m_in_rst = 1'b1; m_sq = '0;
      e.rst = 1'b1;
    end else begin
      if (m_in_rst || !m_s2) m_streak = 0;
      else if (m_streak < 100000) m_streak++;
      e.run = !m_in_rst && (m_streak >= LOCK + 1);
      m_s2 = m_s1; m_s1 = lock_i; m_in_rst = 1'b0;
      if (e.run) begin
        for (int i = 0; i < NCH; i++) begin
          dv = int'(div_i[i*DW +: DW]);
          if (!m_run || sync_i) begin
            m_next[i] = m_cyc + 1 + dv;
            m_sq[i] = 1'b0;
          end else if (m_cyc == m_next[i]) begin
            m_next[i] = m_cyc + 1 + dv;
          end
          e.ce[i] = (m_next[i] == m_cyc + 1);
`ifdef CLKEN_SQUARE_EN
          m_sq[i] = m_sq[i] ^ e.ce[i];
`endif
        end
      end else begin
        m_sq = '0;
      end
      e.rst = !e.run;
      m_run = e.run;
    end
    e.sq = m_sq;
    m_cyc++;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic l, input logic [NCH*DW-1:0] d, input logic s);
    @(negedge clkin);
    reset = r; lock_i = l; div_i = d; sync_i = s;
    model_push();
  endtask

  // Count cycles until run_o rises; the lock-raising step has already been issued.
  task automatic wait_run(input string name, input logic [NCH*DW-1:0] d, input int exp_k);
    int k;
    k = 0;
    while (!run_o && k < 100) begin
      k++;
      step(1'b0, 1'b1, d, 1'b0);
    end
    chk(name, k, exp_k);
  endtask

  // Record ch0..ch2 strobes over RUN cycles 0..13 (cycle 0 is the current one).
  task automatic run_window(input logic [NCH*DW-1:0] d_start, input int chg_cyc,
                            input logic [NCH*DW-1:0] d_chg, input int sync_cyc,
                            output logic [13:0] m0, output logic [13:0] m1, output logic [13:0] m2);
    logic [NCH*DW-1:0] d;
    d = d_start;
    m0 = '0; m1 = '0; m2 = '0;
    m0[0] = ce_o[0]; m1[0] = ce_o[1]; m2[0] = ce_o[2];
    for (int r = 1; r < 14; r++) begin
      if (r == chg_cyc) d = d_chg;
      step(1'b0, 1'b1, d, (r == sync_cyc) ? 1'b1 : 1'b0);
      m0[r] = ce_o[0]; m1[r] = ce_o[1]; m2[r] = ce_o[2];
    end
  endtask

  // Scoreboard monitor: one expected entry per clock once stimulus has started.
  always @(posedge clkin) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({rst_o, run_o, ce_o, sq_o} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got rst=%b run=%b ce=%b sq=%b, expected rst=%b run=%b ce=%b sq=%b",
                 $time, rst_o, run_o, ce_o, sq_o, e.rst, e.run, e.ce, e.sq);
      end
    end
  end

  initial begin
    logic [NCH*DW-1:0] d_a, d_b, d_r;
    logic [13:0]       w0, w1, w2;
    logic              rl, rr, rs;
    int                nrun, ch;

    reset = 1'b1; lock_i = 1'b0; div_i = '0; sync_i = 1'b0;
    d_a = {8'd3, 8'd1, 8'd0, 8'd4};
    d_b = {8'd3, 8'd1, 8'd0, 8'd2};

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, d_a, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, d_a, 1'b0);
    chk("reset_values", int'({rst_o, run_o, ce_o, sq_o}), 32'h200);

    // aborted qualification: lock high for 8 cycles only
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, d_a, 1'b0);
    nrun = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, d_a, 1'b0);
      if (run_o || !rst_o) nrun++;
    end
    chk("abort_no_release", nrun, 0);

    step(1'b0, 1'b1, d_a, 1'b0);
    wait_run("release_latency", d_a, LOCK + 3);
    chk("release_rst_o_low", int'(rst_o), 0);

    run_window(d_a, 2, d_b, -1, w0, w1, w2);
    chk("ch0_div_change_strobes", int'(w0), 32'h2490);
    chk("ch1_div0_constant", int'(w1), 32'h3fff);
    chk("ch2_div1_strobes", int'(w2), 32'h2aaa);

    // lock loss during RUN
    step(1'b0, 1'b0, d_b, 1'b0);
    step(1'b0, 1'b0, d_b, 1'b0);
    step(1'b0, 1'b0, d_b, 1'b0);
    chk("lock_loss_cycle2_still_run", int'(rst_o), 0);
    step(1'b0, 1'b0, d_b, 1'b0);
    chk("lock_loss_cycle3_rst", int'(rst_o), 1);
    chk("lock_loss_cycle3_ce", int'(ce_o), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, d_a, 1'b0);

    step(1'b0, 1'b1, d_a, 1'b0);
    wait_run("relock_latency", d_a, LOCK + 3);
    run_window(d_a, -1, d_a, 7, w0, w1, w2);
    chk("ch0_sync_strobes", int'(w0), 32'h1010);
    chk("ch1_sync_div0", int'(w1), 32'h3fff);
    chk("ch2_sync_strobes", int'(w2), 32'h2aaa);

    // reset in the middle of RUN
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, d_a, 1'b0);
    step(1'b1, 1'b1, d_a, 1'b0);
    step(1'b0, 1'b1, d_a, 1'b0);
    chk("midrun_reset_values", int'({rst_o, run_o, ce_o, sq_o}), 32'h200);
    wait_run("rerelease_after_reset", d_a, LOCK + 3);

    // randomised phase against the reference model
    rl = 1'b1;
    d_r = d_a;
    for (int n = 0; n < 4000; n++) begin
      if (rl) rl = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      else    rl = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
      rr = ($urandom_range(0, 799) == 0) ? 1'b1 : 1'b0;
      rs = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 14) == 0) begin
        ch = int'($urandom_range(0, NCH - 1));
        d_r[ch*DW +: DW] = DW'($urandom_range(0, 9));
      end
      step(rr, rl, d_r, rs);
    end

    step(1'b0, 1'b1, d_r, 1'b0);
    @(posedge clkin);
    #2;
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Parametrised clock-enable and reset sequencer that runs on the PLL output clock. It waits for PLL lock to be stable, releases a synchronous system reset, and then produces NUM_CH independent, phase-alignable clock-enable strobes with run-time divisors. Downstream VDP logic (pixel, VRAM, CPU-interface domains) runs on the single PLL clock and is gated by these strobes, so no extra PLL outputs are needed.

## Interface
- NUM_CH, 4: number of enable channels (1..8).
- DIV_W, 8: divisor/counter width per channel.
- LOCK_CYCLES, 1024: consecutive synchronised-lock cycles required before release (≥1).

- clkin  input  1  PLL output clock; sole clock of the block.
- reset  input  1  synchronous, active-high reset.
- lock_i  input  1  raw PLL lock; asynchronous; synchronised internally.
- div_i  input  NUM_CH*DIV_W  channel i divisor at bits [i*DIV_W +: DIV_W]; period = div+1.
- sync_i  input  1  realign all channel counters (single-cycle pulse, level also legal).
- rst_o  output  1  registered system reset for downstream; high until stable lock.
- ce_o  output  NUM_CH  registered one-cycle enable strobes.
- sq_o  output  NUM_CH  50% duty square per channel (see Configuration).
- run_o  output  1  high while in RUN.

## Operation
- lock_i passes a 2-flop synchroniser (lock_s); the raw value is never used elsewhere.
- FSM states: RST, WAIT, STABLE, RUN.
  - RST: entered on reset=1 (any state). Next cycle → WAIT.
  - WAIT: lock counter cleared; lock_s=1 → STABLE.
  - STABLE: lock counter increments each cycle; lock_s=0 → WAIT (counter cleared); counter reaching LOCK_CYCLES-1 with lock_s=1 → RUN.
  - RUN: lock_s=0 → WAIT. reset has priority over all transitions.
- rst_o=1 in every state except RUN; run_o = (state==RUN). Both are registered.
- Per-channel divider (RUN only): counter cnt runs 0..div_act and wraps to 0; ce_o[i] is high for exactly one cycle per wrap, giving period div_act+1 cycles. div_act=0 → ce_o[i] held high every RUN cycle.
- div_act is loaded from div_i on RUN entry, on every wrap, and on sync_i. Mid-period div_i changes do not truncate or stretch the current period.
- sync_i=1 in RUN: all cnt←0 and div_act reloaded. ce_o is 0 for all channels with div_act>0 in the following cycle, and the strobes then proceed as from RUN entry. sync_i outside RUN is ignored.
- Outside RUN: cnt=0, ce_o=0, sq_o=0.

## Timing
- Reset values (cycle after reset=1): rst_o=1, run_o=0, ce_o=0, sq_o=0, all counters 0, state RST.
- Lock release: lock_i rises at cycle 0 → lock_s high at cycle 2 → rst_o falls and run_o rises at cycle 2+LOCK_CYCLES+1, with lock_i held high throughout.
- Lock loss: lock_i falls at cycle 0 → rst_o=1, run_o=0, ce_o=0 from cycle 3. A lock glitch shorter than the synchroniser window may be missed. That is acceptable.
- Strobe phase: with the first RUN cycle numbered 0, ce_o[i] is high in cycles div, 2·div+1, 3·div+2, … All channels that share a divisor are phase-identical after RUN entry or after sync_i.
- sync_i asserted in cycle s: counters are 0 in cycle s+1, and the first strobe comes at s+1+div_act.
- reset mid-RUN: outputs are at their reset values next cycle. Re-release requires a full lock qualification again.

## Configuration
- CLKEN_SQUARE_EN defined: sq_o[i] toggles on each ce_o[i] pulse, giving a period of 2·(div_act+1) and 50% duty, for pin/ODDR clock forwarding. It is cleared outside RUN and on sync_i. div_act=0 yields sq_o = clkin/2.
- Not defined: sq_o is tied to 0 and its toggle flops are not built.

## Test plan
- LOCK_CYCLES=16, lock_i raised at cycle 10 → rst_o falls at cycle 29; lock_i dropped at cycle 20 instead → rst_o stays high, and qualification restarts on the next rise.
- div ch0=4, ch1=0, ch2=1 → in RUN, ch0 strobes every 5 cycles starting at cycle 4, ch1 is constant 1, ch2 strobes every 2 cycles starting at cycle 1.
- ch0 div changed 4→2 at RUN cycle 2 → strobe still at cycle 4, then at cycles 7, 10, 13.
- sync_i pulse at RUN cycle 7 with ch0 div=4 → no strobe in cycle 8, and the next strobe is at cycle 12.
- lock_i dropped during RUN → rst_o=1 and ce_o=0 three cycles later. Relock must requalify the full LOCK_CYCLES. Repeat with reset=1 mid-RUN → reset values the next cycle.
- With CLKEN_SQUARE_EN and ch0 div=2 → sq_o[0] has a period of 6 cycles, 3 high and 3 low. Without the macro → sq_o stays 0.
